// File: rtl/ex_wb_queue.sv
// ex_wb_queue
//   Buffers completed instruction bundles from execute and retires them in
//   program order. Each bundle carries up to four results: GPR and segment
//   results are written together in one cycle, memory results are sent one
//   at a time over a req/ack store port, and then the bundle retires.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             drop every buffered bundle and any in-flight store
//   in_valid_i/in_ready_o  bundle handshake from execute
//   in_eip_i, in_eflags_i  bundle EIP / flags, returned on retire
//   in_wb_i, in_is_reg_i, in_is_seg_i, in_is_mem_i  per-result enables/classes
//   in_data_i, in_dest_i, in_size_i   result payload (res1 in the LSBs)
//   rf_we_o, sr_we_o    one-cycle GPR / segment write strobes
//   wb_data_o, wb_dest_o, wb_size_o   head bundle payload for rf/sr
//   mem_req_o/mem_ack_i, mem_addr_o, mem_data_o, mem_size_o  store port
//   retire_valid_o, retire_eip_o, retire_eflags_o  one-cycle retire pulse
module ex_wb_queue #(
   parameter int DEPTH = 2,
   parameter int DW    = 64,
   parameter int AW    = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     in_eip_i,
   input  logic [3:0]      in_wb_i,
   input  logic [3:0]      in_is_reg_i,
   input  logic [3:0]      in_is_seg_i,
   input  logic [3:0]      in_is_mem_i,
   input  logic [4*DW-1:0] in_data_i,
   input  logic [4*AW-1:0] in_dest_i,
   input  logic [1:0]      in_size_i,
   input  logic [17:0]     in_eflags_i,
   output logic [3:0]      rf_we_o,
   output logic [3:0]      sr_we_o,
   output logic [4*DW-1:0] wb_data_o,
   output logic [4*AW-1:0] wb_dest_o,
   output logic [1:0]      wb_size_o,
   output logic            mem_req_o,
   input  logic            mem_ack_i,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_data_o,
   output logic [1:0]      mem_size_o,
   output logic            retire_valid_o,
   output logic [31:0]     retire_eip_o,
   output logic [17:0]     retire_eflags_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {S_REG, S_MEM, S_RET} state_e;

   // Bundle storage; class masks are resolved once on the way in.
   logic [31:0]        eip_q  [DEPTH];
   logic [17:0]        efl_q  [DEPTH];
   logic [1:0]         size_q [DEPTH];
   logic [3:0]         regm_q [DEPTH];
   logic [3:0]         segm_q [DEPTH];
   logic [3:0]         memm_q [DEPTH];
   logic [3:0][DW-1:0] data_q [DEPTH];
   logic [3:0][AW-1:0] dest_q [DEPTH];

   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    pend_q, pend_d;
   state_e        state_q;
   logic          push, pop, head_v;
   logic [1:0]    mem_idx;
   logic [3:0]    in_mem, in_seg, in_reg;

   // mem beats seg beats reg; a wb bit with no class lands in no mask.
   assign in_mem = in_wb_i & in_is_mem_i;
   assign in_seg = in_wb_i & in_is_seg_i & ~in_is_mem_i;
   assign in_reg = in_wb_i & in_is_reg_i & ~in_is_seg_i & ~in_is_mem_i;

   assign head_v = (count_q != '0);
   assign push   = in_valid_i & in_ready_o & ~flush_i;
   assign pop    = (state_q == S_RET);
   assign pend_d = pend_q & (pend_q - 4'd1);   // clear lowest pending result

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Lowest pending index gives res1..res4 store order.
   always_comb begin
      mem_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (pend_q[i]) mem_idx = 2'(i);
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         eip_q[wptr_q]  <= in_eip_i;
         efl_q[wptr_q]  <= in_eflags_i;
         size_q[wptr_q] <= in_size_i;
         regm_q[wptr_q] <= in_reg;
         segm_q[wptr_q] <= in_seg;
         memm_q[wptr_q] <= in_mem;
         data_q[wptr_q] <= in_data_i;
         dest_q[wptr_q] <= in_dest_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         state_q <= S_REG;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         pend_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case (state_q)
            S_REG: if (head_v) begin
               pend_q  <= memm_q[rptr_q];
               state_q <= (|memm_q[rptr_q]) ? S_MEM : S_RET;
            end
            S_MEM: if (mem_ack_i) begin
               pend_q <= pend_d;
               if (pend_d == '0) state_q <= S_RET;
            end
            S_RET:   state_q <= S_REG;
            default: state_q <= S_REG;
         endcase
      end
   end

   // Outputs decode from state and head entry; forced to 0 while in reset.
   always_comb begin
      in_ready_o      = 1'b0;
      rf_we_o         = '0;
      sr_we_o         = '0;
      wb_data_o       = '0;
      wb_dest_o       = '0;
      wb_size_o       = '0;
      mem_req_o       = 1'b0;
      mem_addr_o      = '0;
      mem_data_o      = '0;
      mem_size_o      = '0;
      retire_valid_o  = 1'b0;
      retire_eip_o    = '0;
      retire_eflags_o = '0;
      if (!rst_i) begin
         in_ready_o = (count_q != FULL);
         if (head_v) begin
            wb_data_o = data_q[rptr_q];
            wb_dest_o = dest_q[rptr_q];
            wb_size_o = size_q[rptr_q];
            case (state_q)
               S_REG: begin
                  rf_we_o = regm_q[rptr_q];
                  sr_we_o = segm_q[rptr_q];
               end
               S_MEM: begin
                  mem_req_o  = 1'b1;
                  mem_addr_o = dest_q[rptr_q][mem_idx];
                  mem_data_o = data_q[rptr_q][mem_idx];
                  mem_size_o = size_q[rptr_q];
               end
               S_RET: begin
                  retire_valid_o  = 1'b1;
                  retire_eip_o    = eip_q[rptr_q];
                  retire_eflags_o = efl_q[rptr_q];
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ex_wb_queue.sv
// Bench for ex_wb_queue: directed scenarios with literal expectations plus a
// queue-based bundle model compared against every output each cycle.
module tb_ex_wb_queue;
   localparam int DW = 64;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     in_eip = '0;
   logic [3:0]      in_wb = '0, in_is_reg = '0, in_is_seg = '0, in_is_mem = '0;
   logic [4*DW-1:0] in_data = '0;
   logic [4*AW-1:0] in_dest = '0;
   logic [1:0]      in_size = '0;
   logic [17:0]     in_eflags = '0;
   logic [3:0]      rf_we, sr_we;
   logic [4*DW-1:0] wb_data;
   logic [4*AW-1:0] wb_dest;
   logic [1:0]      wb_size;
   logic            mem_req;
   logic            mem_ack = 1'b0;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_data;
   logic [1:0]      mem_size;
   logic            retire_valid;
   logic [31:0]     retire_eip;
   logic [17:0]     retire_eflags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_wb_queue #(.DEPTH(2), .DW(DW), .AW(AW)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_eip_i(in_eip), .in_wb_i(in_wb), .in_is_reg_i(in_is_reg),
      .in_is_seg_i(in_is_seg), .in_is_mem_i(in_is_mem),
      .in_data_i(in_data), .in_dest_i(in_dest), .in_size_i(in_size),
      .in_eflags_i(in_eflags),
      .rf_we_o(rf_we), .sr_we_o(sr_we), .wb_data_o(wb_data),
      .wb_dest_o(wb_dest), .wb_size_o(wb_size),
      .mem_req_o(mem_req), .mem_ack_i(mem_ack), .mem_addr_o(mem_addr),
      .mem_data_o(mem_data), .mem_size_o(mem_size),
      .retire_valid_o(retire_valid), .retire_eip_o(retire_eip),
      .retire_eflags_o(retire_eflags)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: FIFO of bundles + step list for the head -------
   // step -1 = reg/seg write cycle, 0..3 = store of that result, 4 = retire
   typedef struct {
      logic [31:0]     eip;
      logic [17:0]     efl;
      logic [1:0]      size;
      logic [3:0]      rm, sm, mm;
      logic [4*DW-1:0] data;
      logic [4*AW-1:0] dest;
   } bun_t;

   bun_t q[$];
   int   steps[$];

   function automatic bun_t mk();
      bun_t b;
      b.eip = in_eip; b.efl = in_eflags; b.size = in_size;
      b.data = in_data; b.dest = in_dest;
      b.rm = '0; b.sm = '0; b.mm = '0;
      for (int i = 0; i < 4; i++)
         if (in_wb[i]) begin
            if (in_is_mem[i])      b.mm[i] = 1'b1;
            else if (in_is_seg[i]) b.sm[i] = 1'b1;
            else if (in_is_reg[i]) b.rm[i] = 1'b1;
         end
      return b;
   endfunction

   always @(posedge clk) begin
      bit rdy;
      rdy = (q.size() != 2);
      if (rst || flush) begin
         q.delete();
         steps.delete();
      end else begin
         if (steps.size() > 0) begin
            if (steps[0] == 4) begin
               steps.delete(0);
               q.delete(0);
            end else if (steps[0] == -1 || mem_ack) begin
               steps.delete(0);
            end
         end
         if (in_valid && rdy) q.push_back(mk());
         if (steps.size() == 0 && q.size() > 0) begin
            steps.push_back(-1);
            for (int i = 0; i < 4; i++) if (q[0].mm[i]) steps.push_back(i);
            steps.push_back(4);
         end
      end
   end

   always @(negedge clk) begin
      logic            e_rdy, e_req, e_ret;
      logic [3:0]      e_rf, e_sr;
      logic [4*DW-1:0] e_wbd;
      logic [4*AW-1:0] e_wba;
      logic [1:0]      e_wbs, e_ms;
      logic [AW-1:0]   e_ma;
      logic [DW-1:0]   e_md;
      logic [31:0]     e_eip;
      logic [17:0]     e_efl;
      int              st;
      e_rdy = 0; e_req = 0; e_ret = 0; e_rf = 0; e_sr = 0; e_wbd = 0; e_wba = 0;
      e_wbs = 0; e_ms = 0; e_ma = 0; e_md = 0; e_eip = 0; e_efl = 0;
      if (!rst) begin
         e_rdy = (q.size() != 2);
         if (q.size() > 0 && steps.size() > 0) begin
            e_wbd = q[0].data; e_wba = q[0].dest; e_wbs = q[0].size;
            st = steps[0];
            if (st == -1) begin
               e_rf = q[0].rm; e_sr = q[0].sm;
            end else if (st == 4) begin
               e_ret = 1; e_eip = q[0].eip; e_efl = q[0].efl;
            end else begin
               e_req = 1;
               e_ma = q[0].dest[st*AW +: AW];
               e_md = q[0].data[st*DW +: DW];
               e_ms = q[0].size;
            end
         end
      end
      chk("in_ready", in_ready, e_rdy);
      chk("rf_we", rf_we, e_rf);
      chk("sr_we", sr_we, e_sr);
      chk("wb_data", wb_data, e_wbd);
      chk("wb_dest", wb_dest, e_wba);
      chk("wb_size", wb_size, e_wbs);
      chk("mem_req", mem_req, e_req);
      chk("mem_addr", mem_addr, e_ma);
      chk("mem_data", mem_data, e_md);
      chk("mem_size", mem_size, e_ms);
      chk("retire_valid", retire_valid, e_ret);
      chk("retire_eip", retire_eip, e_eip);
      chk("retire_eflags", retire_eflags, e_efl);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] eip, input logic [3:0] wb, input logic [3:0] r,
                        input logic [3:0] s, input logic [3:0] m,
                        input logic [4*DW-1:0] d, input logic [4*AW-1:0] a);
      in_valid = 1'b1; in_eip = eip; in_wb = wb; in_is_reg = r; in_is_seg = s;
      in_is_mem = m; in_data = d; in_dest = a; in_size = 2'd3;
      in_eflags = eip[17:0] ^ 18'h2a5;
   endtask

   initial begin
      // reset
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_rf_we", rf_we, 4'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", in_ready, 1'b1);

      // 1: reg-only bundle
      drive(32'h1000, 4'b0011, 4'b0011, 4'b0, 4'b0, {64'h0, 64'h0, 64'h22, 64'h11}, '0);
      tick(); in_valid = 1'b0;
      chk("t1_rf_we", rf_we, 4'b0011);
      chk("t1_wb_data", wb_data[127:0], {64'h22, 64'h11});
      tick();
      chk("t1_retire", retire_valid, 1'b1);
      chk("t1_retire_eip", retire_eip, 32'h1000);
      chk("t1_rf_we_off", rf_we, 4'd0);
      tick();
      chk("t1_retire_off", retire_valid, 1'b0);

      // 2: reg + one mem result, ack on 3rd request cycle
      drive(32'h2000, 4'b0101, 4'b0001, 4'b0, 4'b0100,
            {64'h0, 64'hAB, 64'h0, 64'h5}, {32'h0, 32'h8000, 32'h0, 32'h0});
      tick(); in_valid = 1'b0;
      chk("t2_rf_we", rf_we, 4'b0001);
      chk("t2_noreq", mem_req, 1'b0);
      mem_ack = 1'b1;                // ack with no request: ignored
      tick(); mem_ack = 1'b0;
      chk("t2_req1", mem_req, 1'b1);
      chk("t2_addr1", mem_addr, 32'h8000);
      tick();
      chk("t2_req2", mem_req, 1'b1);
      tick();
      chk("t2_req3", mem_req, 1'b1);
      chk("t2_data3", mem_data, 64'hAB);
      mem_ack = 1'b1;
      tick(); mem_ack = 1'b0;
      chk("t2_retire", retire_valid, 1'b1);
      chk("t2_retire_eip", retire_eip, 32'h2000);
      chk("t2_req_off", mem_req, 1'b0);
      tick();

      // 3: back-to-back pushes into a 2-deep queue
      drive(32'h3000, 4'b0001, 4'b0001, 4'b0, 4'b0, 256'h1, '0);
      tick();
      drive(32'h3001, 4'b0001, 4'b0001, 4'b0, 4'b0, 256'h2, '0);
      tick();
      chk("t3_full", in_ready, 1'b0);
      chk("t3_ret0", retire_eip, 32'h3000);
      drive(32'h3002, 4'b0001, 4'b0001, 4'b0, 4'b0, 256'h3, '0);
      tick();
      chk("t3_ready_again", in_ready, 1'b1);
      tick(); in_valid = 1'b0;
      chk("t3_ret1", retire_eip, 32'h3001);
      tick();
      tick();
      chk("t3_ret2_v", retire_valid, 1'b1);
      chk("t3_ret2", retire_eip, 32'h3002);
      tick();

      // 4: flush mid-store; same-cycle push and ack are overridden
      drive(32'h4000, 4'b0001, 4'b0, 4'b0, 4'b0001, 256'h44, 128'h9000);
      tick(); in_valid = 1'b0;
      tick();
      chk("t4_req", mem_req, 1'b1);
      flush = 1'b1; mem_ack = 1'b1;
      drive(32'h4100, 4'b0001, 4'b0001, 4'b0, 4'b0, 256'h55, '0);
      tick(); flush = 1'b0; mem_ack = 1'b0; in_valid = 1'b0;
      chk("t4_req_off", mem_req, 1'b0);
      chk("t4_ready", in_ready, 1'b1);
      chk("t4_no_retire", retire_valid, 1'b0);
      chk("t4_no_rf", rf_we, 4'd0);
      tick();
      chk("t4_no_retire2", retire_valid, 1'b0);

      // 5: all classes set -> mem wins, four serialized stores
      drive(32'h5000, 4'hF, 4'hF, 4'hF, 4'hF,
            {64'h103, 64'h102, 64'h101, 64'h100},
            {32'hA003, 32'hA002, 32'hA001, 32'hA000});
      tick(); in_valid = 1'b0;
      chk("t5_rf_we", rf_we, 4'd0);
      chk("t5_sr_we", sr_we, 4'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t5_req", mem_req, 1'b1);
         chk("t5_addr", mem_addr, 32'hA000 + i);
         chk("t5_data", mem_data, 64'h100 + i);
         mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      chk("t5_retire", retire_eip, 32'h5000);
      tick();

      // 6: wb bit with no class
      drive(32'h6000, 4'b0010, 4'b0, 4'b0, 4'b0, 256'h66, '0);
      tick(); in_valid = 1'b0;
      chk("t6_rf_we", rf_we, 4'd0);
      chk("t6_sr_we", sr_we, 4'd0);
      chk("t6_req", mem_req, 1'b0);
      tick();
      chk("t6_retire", retire_valid, 1'b1);
      chk("t6_retire_eip", retire_eip, 32'h6000);
      tick();

      // 7: reset mid-store
      drive(32'h7000, 4'b0001, 4'b0, 4'b0, 4'b0001, 256'h77, 128'hB000);
      tick(); in_valid = 1'b0;
      tick();
      chk("t7_req", mem_req, 1'b1);
      rst = 1'b1;
      tick();
      chk("t7_req_off", mem_req, 1'b0);
      chk("t7_ready_rst", in_ready, 1'b0);
      chk("t7_wb_data", wb_data, 256'd0);
      rst = 1'b0;
      tick();
      chk("t7_ready", in_ready, 1'b1);
      chk("t7_no_retire", retire_valid, 1'b0);

      // random traffic, checked by the model every cycle
      for (int n = 0; n < 400; n++) begin
         logic [4*DW-1:0] d;
         logic [4*AW-1:0] a;
         for (int k = 0; k < 8; k++) begin
            d[k*32 +: 32] = $urandom;
            if (k < 4) a[k*32 +: 32] = $urandom;
         end
         drive($urandom, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), d, a);
         in_size  = 2'($urandom);
         in_valid = ($urandom_range(0, 2) != 0);
         mem_ack  = $urandom_range(0, 1);
         flush    = ($urandom_range(0, 39) == 0);
         tick();
      end
      in_valid = 1'b0; mem_ack = 1'b1; flush = 1'b0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
